seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the calculator's combinational ALU. Accepts operand pairs over a valid/ready handshake, runs single-cycle ops in one clock and multiply/divide iteratively (one bit per clock), and returns a registered result with a double-width product/remainder, sticky carry for chained add/subtract, and a 5-bit flag vector. Sits between the keypad/operand registers and the display driver of the binary calculator.

## Interface
- INBITS, 8, operand/result width (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept a new operation
- in_A  input  INBITS  operand A (unsigned)
- in_B  input  INBITS  operand B (unsigned; shift amount for shifts)
- Sel  input  4  opcode
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Out  output  INBITS  primary result (low product, quotient)
- Out_hi  output  INBITS  high product half (MUL), remainder (DIV), else 0
- Flag  output  5  [0] zero, [1] carry, [2] mul overflow, [3] borrow, [4] divide-by-zero

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 SHL, 5 SHR, 6 AND, 7 OR, 8 XOR, 9 XNOR, A NAND, B NOR (all bitwise), C ADC (A+B+c_q), D SBB (A−B−c_q), E/F illegal.
- Internal c_q: ADD/ADC load carry-out; SUB/SBB load borrow; all other ops leave it unchanged. Reset 0.
- ADD/ADC: {Flag[1],Out}=sum. SUB/SBB: Out=difference mod 2^INBITS, Flag[3]=borrow.
- MUL: shift-add, {Out_hi,Out}=A*B; Flag[2]=|Out_hi.
- DIV: restoring, Out=A/B, Out_hi=A%B, Flag[3]=(A<B). B=0: no iteration, Out=all ones, Out_hi=A, Flag[4]=1.
- SHL/SHR: shift by B, zero fill; B≥INBITS → Out=0. Flag[1]=last bit shifted out (A[INBITS−B] for SHL, A[B−1] for SHR) when 1≤B≤INBITS, else 0.
- Flag[0]=1 when Out==0 and Out_hi==0, for opcodes 0–D only. Unlisted flag bits are 0 for each op.
- Illegal opcodes: Out=0, Out_hi=0, Flag=0, c_q unchanged, latency 1.
- FSM: IDLE → (accept, MUL) MUL → DONE; (accept, DIV with B≠0) DIV → DONE; (accept, other) → DONE. DONE → IDLE on out_ready.
- MUL/DIV use a counter of INBITS iterations; operands are latched at acceptance, later changes on in_A/in_B/Sel are ignored.

## Timing
- Acceptance: in_valid && in_ready at a rising edge. in_ready = (state==IDLE); no overlap of operations.
- Latency (acceptance edge to first out_valid cycle): 1 for single-cycle ops, DIV-by-zero and illegal ops; INBITS+1 for MUL and DIV.
- out_valid held with Out/Out_hi/Flag stable until out_ready sampled high; transfer completes at that edge, out_valid drops next cycle, in_ready rises same cycle. Minimum back-to-back throughput: one op per 2 cycles.
- out_ready high while out_valid low has no effect.
- Reset (any time, including mid-MUL/DIV): state IDLE, in_ready=1 after reset release, out_valid=0, Out=0, Out_hi=0, Flag=0, c_q=0, counter=0; an in-flight operation is discarded.
- All outputs registered; no combinational path input→output except none (in_ready from state only).

## Test plan
- INBITS=8: ADD 200+100 → Out=44, Flag=5'b00010, c_q=1; then ADC 1+1 → Out=3, Flag[1]=0; both latency 1.
- SUB 5−7 → Out=254, Flag[3]=1; SBB 10−3 → Out=6, Flag[3]=0; SUB 9−9 → Out=0, Flag[0]=1.
- MUL 255*255 → out_valid 9 cycles after acceptance, {Out_hi,Out}=16'hFE01, Flag[2]=1; MUL 0*77 → Flag[0]=1, Flag[2]=0.
- DIV 200/7 → Out=28, Out_hi=4, latency 9; DIV 3/0 → Out=255, Out_hi=3, Flag[4]=1, latency 1.
- SHL 8'h81 by 1 → Out=8'h02, Flag[1]=1; SHR 8'h81 by 8 → Out=0, Flag[1]=1, Flag[0]=1; SHL by 9 → Out=0, Flag[1]=0; Sel=E → Out=0, Flag=0.
- Hold out_ready low 5 cycles after a MUL result → outputs stable, in_ready=0, new in_valid ignored; assert rst_n low mid-DIV → out_valid=0, all outputs 0, next op runs correctly.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle between the calculator front end and seq_alu.
interface seq_alu_if #(
   parameter int unsigned INBITS = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [INBITS-1:0] in_A;
   logic [INBITS-1:0] in_B;
   logic [3:0]        Sel;
   logic              out_valid;
   logic              out_ready;
   logic [INBITS-1:0] Out;
   logic [INBITS-1:0] Out_hi;
   logic [4:0]        Flag;

   modport master (
      output in_valid, in_A, in_B, Sel, out_ready,
      input  in_ready, out_valid, Out, Out_hi, Flag
   );

   modport slave (
      input  in_valid, in_A, in_B, Sel, out_ready,
      output in_ready, out_valid, Out, Out_hi, Flag
   );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle calculator ALU: single-cycle logic/arith/shift ops, iterative
// shift-add multiply and restoring divide, registered results and flags.
module seq_alu #(
   parameter int unsigned INBITS = 8
) (
   input logic      clk,
   input logic      rst_n,
   seq_alu_if.slave alu_io
);
   localparam int unsigned CntW = $clog2(INBITS);

   localparam logic [3:0] OpAdd  = 4'h0;
   localparam logic [3:0] OpSub  = 4'h1;
   localparam logic [3:0] OpMul  = 4'h2;
   localparam logic [3:0] OpDiv  = 4'h3;
   localparam logic [3:0] OpShl  = 4'h4;
   localparam logic [3:0] OpShr  = 4'h5;
   localparam logic [3:0] OpAnd  = 4'h6;
   localparam logic [3:0] OpOr   = 4'h7;
   localparam logic [3:0] OpXor  = 4'h8;
   localparam logic [3:0] OpXnor = 4'h9;
   localparam logic [3:0] OpNand = 4'hA;
   localparam logic [3:0] OpNor  = 4'hB;
   localparam logic [3:0] OpAdc  = 4'hC;
   localparam logic [3:0] OpSbb  = 4'hD;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

   state_e            state_q;
   logic [INBITS-1:0] a_q, b_q, out_q, out_hi_q;
   logic [4:0]        flag_q;
   logic              c_q, out_valid_q;
   logic [CntW-1:0]   cnt_q;

   logic              cin;
   logic [INBITS:0]   sum_w, diff_w, shl_w, shr_w;
   logic [INBITS-1:0] sc_out, sc_hi;
   logic [4:0]        sc_flag;
   logic              sc_c_d;

   always_comb begin
      cin     = ((alu_io.Sel == OpAdc) || (alu_io.Sel == OpSbb)) ? c_q : 1'b0;
      sum_w   = {1'b0, alu_io.in_A} + {1'b0, alu_io.in_B} + {{INBITS{1'b0}}, cin};
      diff_w  = {1'b0, alu_io.in_A} - {1'b0, alu_io.in_B} - {{INBITS{1'b0}}, cin};
      // Extra guard bit catches the last bit shifted out in either direction.
      shl_w   = {1'b0, alu_io.in_A} << alu_io.in_B;
      shr_w   = {alu_io.in_A, 1'b0} >> alu_io.in_B;
      sc_out  = '0;
      sc_hi   = '0;
      sc_flag = '0;
      sc_c_d  = c_q;
      case (alu_io.Sel)
         OpAdd, OpAdc: begin
            sc_out     = sum_w[INBITS-1:0];
            sc_flag[1] = sum_w[INBITS];
            sc_c_d     = sum_w[INBITS];
         end
         OpSub, OpSbb: begin
            sc_out     = diff_w[INBITS-1:0];
            sc_flag[3] = diff_w[INBITS];
            sc_c_d     = diff_w[INBITS];
         end
         OpDiv: begin
            // Only reached for a zero divisor; nonzero divisors iterate.
            sc_out     = '1;
            sc_hi      = alu_io.in_A;
            sc_flag[4] = 1'b1;
         end
         OpShl: begin
            sc_out     = shl_w[INBITS-1:0];
            sc_flag[1] = shl_w[INBITS];
         end
         OpShr: begin
            sc_out     = shr_w[INBITS:1];
            sc_flag[1] = shr_w[0];
         end
         OpAnd:   sc_out = alu_io.in_A & alu_io.in_B;
         OpOr:    sc_out = alu_io.in_A | alu_io.in_B;
         OpXor:   sc_out = alu_io.in_A ^ alu_io.in_B;
         OpXnor:  sc_out = ~(alu_io.in_A ^ alu_io.in_B);
         OpNand:  sc_out = ~(alu_io.in_A & alu_io.in_B);
         OpNor:   sc_out = ~(alu_io.in_A | alu_io.in_B);
         default: ;
      endcase
      if (alu_io.Sel <= OpSbb) begin
         sc_flag[0] = (sc_out == '0) && (sc_hi == '0);
      end
   end

   logic [INBITS:0]   mul_sum, rem_sh, trial;
   logic [INBITS-1:0] it_hi, it_lo;

   // Out_hi/Out double as the product or remainder/quotient work registers.
   always_comb begin
      mul_sum = {1'b0, out_hi_q} + (out_q[0] ? {1'b0, a_q} : {(INBITS + 1){1'b0}});
      rem_sh  = {out_hi_q, out_q[INBITS-1]};
      trial   = rem_sh - {1'b0, b_q};
      if (state_q == StMul) begin
         it_hi = mul_sum[INBITS:1];
         it_lo = {mul_sum[0], out_q[INBITS-1:1]};
      end else if (trial[INBITS]) begin
         it_hi = rem_sh[INBITS-1:0];
         it_lo = {out_q[INBITS-2:0], 1'b0};
      end else begin
         it_hi = trial[INBITS-1:0];
         it_lo = {out_q[INBITS-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         out_q       <= '0;
         out_hi_q    <= '0;
         flag_q      <= '0;
         c_q         <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (alu_io.in_valid) begin
                  a_q   <= alu_io.in_A;
                  b_q   <= alu_io.in_B;
                  cnt_q <= '0;
                  if (alu_io.Sel == OpMul) begin
                     out_hi_q <= '0;
                     out_q    <= alu_io.in_B;
                     state_q  <= StMul;
                  end else if ((alu_io.Sel == OpDiv) && (alu_io.in_B != '0)) begin
                     out_hi_q <= '0;
                     out_q    <= alu_io.in_A;
                     state_q  <= StDiv;
                  end else begin
                     out_q       <= sc_out;
                     out_hi_q    <= sc_hi;
                     flag_q      <= sc_flag;
                     c_q         <= sc_c_d;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end
               end
            end
            StMul, StDiv: begin
               out_hi_q <= it_hi;
               out_q    <= it_lo;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CntW'(INBITS - 1)) begin
                  flag_q      <= {1'b0,
                                  (state_q == StDiv) && (a_q < b_q),
                                  (state_q == StMul) && (it_hi != '0),
                                  1'b0,
                                  (it_hi == '0) && (it_lo == '0)};
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (alu_io.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign alu_io.in_ready  = (state_q == StIdle);
   assign alu_io.out_valid = out_valid_q;
   assign alu_io.Out       = out_q;
   assign alu_io.Out_hi    = out_hi_q;
   assign alu_io.Flag      = flag_q;
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed calculator cases, random ops with random
// back-pressure, output hold, and reset during a divide.
module tb_seq_alu;
   localparam int unsigned N = 8;

   typedef struct packed {
      logic [N-1:0] out;
      logic [N-1:0] hi;
      logic [4:0]   flag;
      int unsigned  lat;
      int unsigned  acc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   seq_alu_if #(.INBITS(N)) bus ();

   seq_alu #(.INBITS(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .alu_io (bus)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   exp_t        sb[$];
   logic        c_m = 1'b0;
   bit          hold = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Reference model: plain integer arithmetic on the opcode table; c_m is the chained carry.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic [3:0] sel);
      exp_t            e;
      int              ai, bi, s;
      longint unsigned p;
      ai = int'(a);
      bi = int'(b);
      e = '0;
      e.lat = 1;
      case (sel)
         4'h0, 4'hC: begin
            s = ai + bi + ((sel == 4'hC) ? int'(c_m) : 0);
            e.out = N'(s);
            e.flag[1] = (s >= (1 << N));
            c_m = e.flag[1];
         end
         4'h1, 4'hD: begin
            s = ai - bi - ((sel == 4'hD) ? int'(c_m) : 0);
            e.out = N'(s);
            e.flag[3] = (s < 0);
            c_m = e.flag[3];
         end
         4'h2: begin
            p = longint'(ai) * longint'(bi);
            e.out = N'(p);
            e.hi = N'(p >> N);
            e.flag[2] = ((p >> N) != 0);
            e.lat = N + 1;
         end
         4'h3: begin
            if (bi == 0) begin
               e.out = '1;
               e.hi = a;
               e.flag[4] = 1'b1;
            end else begin
               e.out = N'(ai / bi);
               e.hi = N'(ai % bi);
               e.flag[3] = (ai < bi);
               e.lat = N + 1;
            end
         end
         4'h4: begin
            e.out = (bi >= int'(N)) ? '0 : N'(ai << bi);
            e.flag[1] = (bi >= 1) && (bi <= int'(N)) && (((ai >> (int'(N) - bi)) & 1) != 0);
         end
         4'h5: begin
            e.out = (bi >= int'(N)) ? '0 : N'(ai >> bi);
            e.flag[1] = (bi >= 1) && (bi <= int'(N)) && (((ai >> (bi - 1)) & 1) != 0);
         end
         4'h6: e.out = a & b;
         4'h7: e.out = a | b;
         4'h8: e.out = a ^ b;
         4'h9: e.out = ~(a ^ b);
         4'hA: e.out = ~(a & b);
         4'hB: e.out = ~(a | b);
         default: ;
      endcase
      if (sel <= 4'hD) e.flag[0] = (e.out == '0) && (e.hi == '0);
      return e;
   endfunction

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] sel);
      exp_t e;
      int   n;
      @(negedge clk);
      bus.in_A = a;
      bus.in_B = b;
      bus.Sel = sel;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         tests++;
         errors++;
         $display("FAIL accept_timeout: in_ready=0, expected 1 within 200 cycles");
         bus.in_valid = 1'b0;
         return;
      end
      e = model(a, b, sel);
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      // Scramble the inputs so any use of unlatched operands shows up.
      bus.in_valid = 1'b0;
      bus.in_A = N'($urandom);
      bus.in_B = N'($urandom);
      bus.Sel = 4'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || !bus.in_ready) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         tests++;
         errors++;
         $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      end
   endtask

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      exp_t e;
      bit   prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 1'b0;
         end else begin
            if (bus.out_valid) begin
               if (sb.size() == 0) begin
                  if (!prev) begin
                     tests++;
                     errors++;
                     $display("FAIL unexpected_result: out_valid=1 with nothing pending, expected 0");
                  end
               end else begin
                  e = sb[0];
                  if (!prev) check("latency", cyc - e.acc, e.lat);
                  if (bus.out_ready) begin
                     check("Out", 32'(bus.Out), 32'(e.out));
                     check("Out_hi", 32'(bus.Out_hi), 32'(e.hi));
                     check("Flag", 32'(bus.Flag), 32'(e.flag));
                     void'(sb.pop_front());
                  end
               end
            end
            prev = bus.out_valid;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [N-1:0] ra, rb;
      logic [3:0]   rs;
      int           n;

      bus.in_valid = 1'b0;
      bus.in_A = '0;
      bus.in_B = '0;
      bus.Sel = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_Out", 32'(bus.Out), 32'd0);
      check("rst_Out_hi", 32'(bus.Out_hi), 32'd0);
      check("rst_Flag", 32'(bus.Flag), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);

      do_op(8'd200, 8'd100, 4'h0);
      do_op(8'd1, 8'd1, 4'hC);
      do_op(8'd5, 8'd7, 4'h1);
      do_op(8'd10, 8'd3, 4'hD);
      do_op(8'd9, 8'd9, 4'h1);
      do_op(8'd255, 8'd255, 4'h2);
      do_op(8'd0, 8'd77, 4'h2);
      do_op(8'd200, 8'd7, 4'h3);
      do_op(8'd3, 8'd0, 4'h3);
      do_op(8'h81, 8'd1, 4'h4);
      do_op(8'h81, 8'd8, 4'h5);
      do_op(8'h81, 8'd9, 4'h4);
      do_op(8'h5A, 8'h33, 4'hE);
      for (int op = 6; op <= 11; op++) do_op(8'hF0, 8'h3C, 4'(op));
      drain();

      // Back-pressure: result must hold and a new request must be refused.
      hold = 1'b1;
      bus.out_ready = 1'b0;
      do_op(8'd255, 8'd255, 4'h2);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      bus.in_A = 8'd1;
      bus.in_B = 8'd1;
      bus.Sel = 4'h0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_Out", 32'(bus.Out), 32'h01);
         check("hold_Out_hi", 32'(bus.Out_hi), 32'hFE);
         check("hold_Flag", 32'(bus.Flag), 32'b00100);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      hold = 1'b0;
      drain();

      for (int i = 0; i < 300; i++) begin
         rs = 4'($urandom_range(0, 15));
         ra = N'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, N + 1)) : N'($urandom);
         do_op(ra, rb, rs);
      end
      drain();

      // Leave carry set, then reset in the middle of a divide.
      do_op(8'd200, 8'd100, 4'h0);
      drain();
      bus.in_A = 8'd200;
      bus.in_B = 8'd7;
      bus.Sel = 4'h3;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("div_busy_in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_Out", 32'(bus.Out), 32'd0);
      check("midrst_Out_hi", 32'(bus.Out_hi), 32'd0);
      check("midrst_Flag", 32'(bus.Flag), 32'd0);
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      c_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_op(8'd1, 8'd1, 4'hC);
      do_op(8'd200, 8'd7, 4'h3);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule
